axis_channel_packer: RTL and testbench
======================================

Name: axis_channel_packer

Overview:
- Parametrised successor to the 8-channel flag-gated stream mux.
- Waits until every enabled channel presents a valid sample, captures all samples in one cycle and packs them into one wide AXI4-Stream beat.
- Drives a compliant master handshake: data is held until accepted.
- Generates tlast on fixed-length frames.
- Sits between the per-channel ADC/FFT front-ends and the DMA/FIFO stream input.

Parameters:
- NUM_CH, 8, number of input channels (1..16).
- CH_W, 32, bits per channel sample.
- FRAME_LEN, 256, beats per frame; tlast is asserted on beat FRAME_LEN-1 (≥1).
- BEAT_W, $clog2(FRAME_LEN)+1 (derived, localparam), width of the beat counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; arms the packer.
- stop  in  1  single-cycle pulse; finish the current frame, then disarm.
- ch_data  in  NUM_CH*CH_W  channel k occupies bits [k*CH_W +: CH_W].
- ch_valid  in  NUM_CH  per-channel sample-ready.
- ch_ack  out  NUM_CH  one-cycle pulse: sample consumed, channel may advance.
- m_axis_tdata  out  NUM_CH*CH_W  packed beat; channel 0 in the LSBs.
- m_axis_tvalid  out  1  AXI-S valid.
- m_axis_tready  in  1  AXI-S ready.
- m_axis_tlast  out  1  last beat of a frame.
- busy  out  1  high while the packer is armed or a beat is pending.
- frame_cnt  out  16  completed frames; wraps at 0xFFFF.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - FSM to IDLE;
  - beat counter, frame_cnt and stop_req to 0;
  - m_axis_tvalid, m_axis_tlast, ch_ack and busy to 0;
  - m_axis_tdata to 0.
- Reset mid-frame drops any pending beat with no tlast emitted.
- FSM states:
  - IDLE: start → ARMED. All other inputs are ignored.
  - ARMED: capture fires when all enabled ch_valid are 1 AND the output register is free (tvalid=0, or tvalid=1 with tready=1 this cycle).
  - On capture:
    - tdata and tvalid load on the next edge, tvalid=1;
    - tlast=1 iff the beat counter equals FRAME_LEN-1;
    - ch_ack pulses for exactly one cycle (the cycle after the capture condition, aligned with tvalid rising);
    - the beat counter increments, or wraps to 0 after the last beat.
  - DRAIN: entered when stop_req is set and the tlast beat has been accepted, or immediately if stop arrives with beat counter 0 and no pending beat. DRAIN → IDLE once tvalid=0.
- Handshake:
  - tvalid, tdata and tlast stay stable while tvalid=1 and tready=0.
  - Back-to-back beats are allowed: a new capture in the same cycle as acceptance gives full throughput of one beat per cycle.
  - Latency is one cycle from capture condition to tvalid.
- stop is latched into stop_req. The frame in progress always completes with a proper tlast. stop together with start in IDLE: start wins and stop_req is set, so exactly one frame is produced.
- start while ARMED is ignored. It does not reset the beat counter.
- frame_cnt increments on acceptance (tvalid&tready) of a tlast beat.
- busy = (state≠IDLE) | tvalid.
- A partial ch_valid pattern never captures. Channels not yet valid only stall; there is no timeout.

Optional Feature:
- Macro PACKER_CHMASK_EN.
- Defined:
  - adds input ch_mask[NUM_CH], sampled only in IDLE on the start cycle;
  - masked channels are excluded from the all-valid condition, receive no ch_ack, and their lane in tdata is driven 0;
  - an all-zero mask is treated as all-enabled.
- Undefined: every channel is enabled; the port does not exist.

Decomposition:
- Shared package axis_pack_pkg holds:
  - the FSM state enum (IDLE, ARMED, DRAIN);
  - a function lane(k) returning the bit offset k*CH_W;
  - the frame_cnt width constant 16.
- One natural sub-module: axis_out_reg, the single-entry output register with the valid/ready hold logic, reusable by other stream sources.

Test Plan:
- NUM_CH=8, FRAME_LEN=4, tready=1, all ch_valid=1, start pulse → 4 consecutive beats; tlast on beat 3 only; ch_ack=0xFF each cycle; frame_cnt=1 after 4 beats; continuous thereafter.
- ch_data[k]=0xA0+k, ch_valid=0x7F for 10 cycles, then 0xFF → no tvalid during the 10 cycles; one beat with tdata=0xA7_A6…A0 lanes; ch_ack=0xFF exactly once.
- tready held 0 for 5 cycles with a beat pending → tdata/tlast stable, no new ch_ack; on tready=1 the beat is accepted and the next capture occurs in the same cycle.
- stop pulsed during beat 1 of a FRAME_LEN=4 frame → beats 2 and 3 still sent, tlast on 3, then IDLE, busy=0, frame_cnt +1.
- rst_n=0 for one cycle mid-frame with tvalid=1, tready=0 → all outputs 0 next cycle; after start, the beat counter restarts at 0 (tlast on the 4th new beat).
- With PACKER_CHMASK_EN: ch_mask=0x0F, ch_valid=0x0F → beats produced; lanes 4–7 are 0; ch_ack=0x0F.

Source files
------------

// File: rtl/axis_pack_pkg.sv
// Shared types and helpers for the AXI4-Stream channel packer and its output stage.
package axis_pack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } pack_state_e;

  localparam int unsigned FRAME_CNT_W = 16;

  function automatic int unsigned lane(input int unsigned k, input int unsigned ch_w);
    return k * ch_w;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register: holds data/last stable until the beat is accepted.
module axis_out_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         tready_i,
  output logic         tvalid_o,
  output logic [W-1:0] tdata_o,
  output logic         tlast_o,
  output logic         free_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && tready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // A new load is legal in the same cycle the held beat is accepted.
  assign free_o   = ~valid_q | tready_i;
  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
  assign tlast_o  = last_q;

endmodule

// File: rtl/axis_channel_packer.sv
// Packs one sample from every enabled channel into a wide AXI4-Stream beat with framed tlast.
// Optional build macro PACKER_CHMASK_EN adds a per-channel enable mask sampled on start.
module axis_channel_packer
  import axis_pack_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned CH_W      = 32,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
`ifdef PACKER_CHMASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH*CH_W-1:0]   m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic [FRAME_CNT_W-1:0]   frame_cnt
);

  localparam int unsigned BEAT_W = $clog2(FRAME_LEN) + 1;
  localparam int unsigned DATA_W = NUM_CH * CH_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  pack_state_e             state_q, state_d;
  logic                    stop_req_q, stop_req_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [FRAME_CNT_W-1:0]  frame_q, frame_d;
  logic [NUM_CH-1:0]       ack_q, ack_d;
  logic [NUM_CH-1:0]       en_mask;
  logic [DATA_W-1:0]       cap_data;
  logic                    out_tvalid, out_tlast, out_free;
  logic                    all_valid, stop_now, accept, capture, drain_now;

`ifdef PACKER_CHMASK_EN
  logic [NUM_CH-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (state_q == IDLE && start) begin
      mask_d = (ch_mask == {NUM_CH{1'b0}}) ? {NUM_CH{1'b1}} : ch_mask;
    end else begin
      mask_d = mask_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mask_q <= {NUM_CH{1'b1}};
    else        mask_q <= mask_d;
  end

  assign en_mask = mask_q;
`else
  assign en_mask = {NUM_CH{1'b1}};
`endif

  always_comb begin
    cap_data = {DATA_W{1'b0}};
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cap_data[lane(k, CH_W) +: CH_W] = en_mask[k] ? ch_data[lane(k, CH_W) +: CH_W] : {CH_W{1'b0}};
    end
  end

  // A pending tlast beat under a stop request blocks further captures; a stop with nothing in flight drains at once.
  assign all_valid = &(ch_valid | ~en_mask);
  assign stop_now  = stop | stop_req_q;
  assign accept    = out_tvalid & m_axis_tready;
  assign drain_now = stop & (beat_q == {BEAT_W{1'b0}}) & ~out_tvalid;
  assign capture   = (state_q == ARMED) & all_valid & out_free
                   & ~(stop_now & out_tvalid & out_tlast) & ~drain_now;

  always_comb begin
    state_d    = state_q;
    stop_req_d = stop_req_q;
    beat_d     = beat_q;
    frame_d    = frame_q;
    ack_d      = {NUM_CH{1'b0}};
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARMED;
          stop_req_d = stop;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        stop_req_d = stop_req_q | stop;
        if (stop_now && accept && out_tlast) state_d = DRAIN;
        else if (drain_now)                  state_d = DRAIN;
        else                                 state_d = ARMED;
      end
      DRAIN: begin
        if (!out_tvalid) begin
          state_d    = IDLE;
          stop_req_d = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d    = IDLE;
        stop_req_d = 1'b0;
      end
    endcase
    if (capture) begin
      ack_d  = en_mask;
      beat_d = (beat_q == LAST_BEAT) ? {BEAT_W{1'b0}} : beat_q + BEAT_W'(1);
    end else begin
      beat_d = beat_q;
    end
    if (accept && out_tlast) frame_d = frame_q + FRAME_CNT_W'(1);
    else                     frame_d = frame_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stop_req_q <= 1'b0;
      beat_q     <= {BEAT_W{1'b0}};
      frame_q    <= {FRAME_CNT_W{1'b0}};
      ack_q      <= {NUM_CH{1'b0}};
    end else begin
      state_q    <= state_d;
      stop_req_q <= stop_req_d;
      beat_q     <= beat_d;
      frame_q    <= frame_d;
      ack_q      <= ack_d;
    end
  end

  axis_out_reg #(.W(DATA_W)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (capture),
    .data_i   (cap_data),
    .last_i   (beat_q == LAST_BEAT),
    .tready_i (m_axis_tready),
    .tvalid_o (out_tvalid),
    .tdata_o  (m_axis_tdata),
    .tlast_o  (out_tlast),
    .free_o   (out_free)
  );

  assign m_axis_tvalid = out_tvalid;
  assign m_axis_tlast  = out_tlast;
  assign ch_ack        = ack_q;
  assign frame_cnt     = frame_q;
  assign busy          = (state_q != IDLE) | out_tvalid;

endmodule

// File: tb/tb_axis_channel_packer.sv
// Self-checking bench for axis_channel_packer (NUM_CH=8, CH_W=8, FRAME_LEN=4); covers PACKER_CHMASK_EN when defined.
module tb_axis_channel_packer;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 8;
  localparam int DW     = NUM_CH * CH_W;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, m_axis_tready;
  logic [DW-1:0] ch_data;
  logic [7:0]    ch_valid;
  logic [7:0]    ch_ack;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, busy;
  logic [15:0]   frame_cnt;
`ifdef PACKER_CHMASK_EN
  logic [7:0]    ch_mask;
`endif

  always #5 clk = ~clk;

  axis_channel_packer #(.NUM_CH(NUM_CH), .CH_W(CH_W), .FRAME_LEN(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .ch_data       (ch_data),
    .ch_valid      (ch_valid),
`ifdef PACKER_CHMASK_EN
    .ch_mask       (ch_mask),
`endif
    .ch_ack        (ch_ack),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [7:0] valid;
    logic       rdy;
    logic       stp;
    logic [7:0] base;
    logic       cap;
    logic       last;
    logic [7:0] ack;
    logic       tv;
  } vec_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [DW-1:0] pat(input logic [7:0] base);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) r[k*CH_W +: CH_W] = base + 8'(k);
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] valid, input logic rdy, input logic stp,
                              input logic [7:0] base, input logic cap, input logic last,
                              input logic [7:0] ack, input logic tv);
    vec_t v;
    v.valid = valid; v.rdy = rdy; v.stp = stp; v.base = base;
    v.cap = cap; v.last = last; v.ack = ack; v.tv = tv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  // Scoreboard: a beat is accepted on the coming edge when valid and ready are both high now.
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got beat %h last %b, expected none", m_axis_tdata, m_axis_tlast);
      end else begin
        beat_t e;
        e = sb.pop_front();
        n_cmp++;
        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
          n_bad++;
          $display("FAIL sb_beat: got %h/%b expected %h/%b", m_axis_tdata, m_axis_tlast, e.data, e.last);
        end
      end
    end
  end

  vec_t          tbl[21];
  logic [DW-1:0] cap_data;
  logic          cap_last;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
    ch_data = '0; ch_valid = 8'h00;
`ifdef PACKER_CHMASK_EN
    ch_mask = 8'h00;
`endif
    cap_data = '0; cap_last = 1'b0;

    for (int i = 0; i < 10; i++) tbl[i] = mk(8'h7F, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[10] = mk(8'hFF, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, 8'hFF, 1'b1);
    tbl[11] = mk(8'h00, 1'b1, 1'b0, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b0);
    tbl[12] = mk(8'hFF, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 8'hFF, 1'b1);
    for (int i = 13; i < 18; i++) tbl[i] = mk(8'hFF, 1'b0, 1'b0, 8'hD0, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[18] = mk(8'hFF, 1'b1, 1'b0, 8'hE0, 1'b1, 1'b0, 8'hFF, 1'b1);
    tbl[19] = mk(8'hFF, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b1, 8'hFF, 1'b1);
    tbl[20] = mk(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_ack", 64'(ch_ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full throughput: three frames back to back
    start = 1'b1; ch_valid = 8'hFF; tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ch_data = pat(8'(i * 16));
      push(ch_data, (i % 4) == 3);
      tick();
      chk("thru_ack", 64'(ch_ack), 64'hFF);
      chk("thru_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("thru_tlast", 64'(m_axis_tlast), 64'((i % 4) == 3));
    end
    ch_valid = 8'h00; stop = 1'b1; tick(); stop = 1'b0;
    tick();
    chk("thru_busy_end", 64'(busy), 64'd0);
    chk("thru_frame_cnt", 64'(frame_cnt), 64'd3);

    // Table: partial valid stall, backpressure hold, back-to-back accept+capture, stop on last beat
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      ch_valid = tbl[i].valid;
      m_axis_tready = tbl[i].rdy;
      stop = tbl[i].stp;
      ch_data = pat(tbl[i].base);
      if (tbl[i].cap) begin
        push(ch_data, tbl[i].last);
        cap_data = ch_data;
        cap_last = tbl[i].last;
      end
      tick();
      chk($sformatf("tbl%0d_ack", i), 64'(ch_ack), 64'(tbl[i].ack));
      chk($sformatf("tbl%0d_tvalid", i), 64'(m_axis_tvalid), 64'(tbl[i].tv));
      if (tbl[i].tv) begin
        chk($sformatf("tbl%0d_tdata", i), m_axis_tdata, cap_data);
        chk($sformatf("tbl%0d_tlast", i), 64'(m_axis_tlast), 64'(cap_last));
      end
    end
    stop = 1'b0; m_axis_tready = 1'b1;
    tick(); tick();
    chk("tbl_busy_end", 64'(busy), 64'd0);
    chk("tbl_frame_cnt", 64'(frame_cnt), 64'd4);

    // Stop during beat 1: frame still completes, then no further captures
    start = 1'b1; ch_valid = 8'hFF; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_data = pat(8'h20 + 8'(i * 16));
      stop = (i == 1);
      push(ch_data, i == 3);
      tick();
    end
    stop = 1'b0;
    chk("stop_tlast", 64'(m_axis_tlast), 64'd1);
    repeat (4) tick();
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("stop_frame_cnt", 64'(frame_cnt), 64'd5);

    // Reset mid-frame with a stalled beat: dropped, beat counter restarts
    start = 1'b1; tick(); start = 1'b0;
    m_axis_tready = 1'b0; ch_data = pat(8'h30); tick();
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    ch_valid = 8'h00; rst_n = 1'b0; tick();
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_tdata", m_axis_tdata, 64'd0);
    chk("mid_rst_ack", 64'(ch_ack), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1; m_axis_tready = 1'b1; tick();
    start = 1'b1; ch_valid = 8'hFF; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_data = pat(8'h40 + 8'(i * 16));
      push(ch_data, i == 3);
      tick();
      chk("rst_restart_tlast", 64'(m_axis_tlast), 64'(i == 3));
    end
    ch_valid = 8'h00; stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("rst_restart_frame_cnt", 64'(frame_cnt), 64'd1);

`ifdef PACKER_CHMASK_EN
    // Mask 0x0F sampled on start only; upper lanes zeroed, no ack on masked channels
    ch_mask = 8'h0F; start = 1'b1; tick(); start = 1'b0; ch_mask = 8'h00;
    ch_valid = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      ch_data = pat(8'h50 + 8'(i * 16));
      push(ch_data & 64'h0000_0000_FFFF_FFFF, i == 3);
      tick();
      chk("mask_ack", 64'(ch_ack), 64'h0F);
      chk("mask_tdata", m_axis_tdata, ch_data & 64'h0000_0000_FFFF_FFFF);
    end
    ch_valid = 8'h00; stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("mask_frame_cnt", 64'(frame_cnt), 64'd2);
`endif

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
